// File: rtl/zkp_trace_buffer.sv
// ---------------------------------------------------------------------------
// zkp_trace_buffer
//
// Captures per-cycle core trace records into a FIFO and serializes each record
// as six 32-bit words on a valid/ready stream for a downstream prover.
//
// Handshake: a word moves only on a rising edge where m_valid=1 and m_ready=1.
// While m_valid=1 and m_ready=0, m_data and m_last hold stable. m_valid never
// depends combinationally on m_ready.
//
// Record word order: 0 = {29'b0, mismatch, is_bne, is_beq}, 1 = pc,
// 2 = pc_next, 3 = rs1_val, 4 = rs2_val, 5 = imm (m_last=1 on word 5).
//
// Optional feature (macro TRACE_CHECK_EN): pc_next checker. When defined,
// each captured record is compared against the architecturally expected next
// pc. A mismatch sets the record's mismatch bit and the sticky check_err,
// even if the record itself is dropped. When undefined, both are constant 0.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   pc, pc_next, rs1_val,   trace fields for the current cycle
//   rs2_val, imm
//   is_beq, is_bne          branch-type flags
//   capture_en              sample this cycle's fields as one record
//   flush                   synchronous clear of FIFO, serializer and status
//   m_valid/m_data/m_last   serialized output stream
//   m_ready                 downstream accepts the current word
//   fifo_count              records stored (excluding the one being sent)
//   overflow, drop_count    sticky drop flag, saturating drop counter
//   check_err               sticky pc_next mismatch flag
// ---------------------------------------------------------------------------
module zkp_trace_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc,
  input  logic [31:0] pc_next,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic        is_beq,
  input  logic        is_bne,
  input  logic        capture_en,
  input  logic        flush,
  output logic        m_valid,
  output logic [31:0] m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic [6:0]  fifo_count,
  output logic        overflow,
  output logic [15:0] drop_count,
  output logic        check_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = 163;
  localparam logic [6:0] DEPTH_C = 7'(DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  // Record layout: {mismatch, is_bne, is_beq, pc, pc_next, rs1, rs2, imm}
  logic [RW-1:0] mem_q [DEPTH];
  logic [RW-1:0] new_rec;
  logic [RW-1:0] head_rec;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [6:0]    count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_q, drop_d;
  logic          check_err_q, check_err_d;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [RW-1:0] rec_q, rec_d;

  logic          pop;
  logic          push;
  logic          drop;
  logic          full;
  logic          mismatch;

  // -------------------------------------------------------------------------
  // pc_next checker
  // -------------------------------------------------------------------------
`ifdef TRACE_CHECK_EN
  logic        br_taken;
  logic [31:0] pc_expected;
  assign br_taken    = (is_beq && (rs1_val == rs2_val)) ||
                       (is_bne && (rs1_val != rs2_val));
  assign pc_expected = br_taken ? (pc + imm) : (pc + 32'd4);
  assign mismatch    = (pc_next != pc_expected);
`else
  assign mismatch    = 1'b0;
`endif

  assign new_rec  = {mismatch, is_bne, is_beq, pc, pc_next, rs1_val, rs2_val, imm};
  assign head_rec = mem_q[rd_ptr_q];
  assign full     = (count_q == DEPTH_C);

  // -------------------------------------------------------------------------
  // Serializer: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rec_q   <= rec_d;
    end
  end

  // -------------------------------------------------------------------------
  // Serializer: next-state logic. The head record is popped on entry to SEND
  // and again on the last-word transfer so records stream without a bubble.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rec_d   = rec_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != 7'd0) begin
            pop     = 1'b1;
            state_d = S_SEND;
            idx_d   = 3'd0;
            rec_d   = head_rec;
          end
        end
        S_SEND: begin
          if (m_ready) begin
            if (idx_q == 3'd5) begin
              idx_d = 3'd0;
              if (count_q != 7'd0) begin
                pop   = 1'b1;
                rec_d = head_rec;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Serializer: outputs. m_data is forced to zero outside SEND.
  // -------------------------------------------------------------------------
  always_comb begin
    m_valid = (state_q == S_SEND);
    m_last  = (state_q == S_SEND) && (idx_q == 3'd5);
    m_data  = 32'd0;
    if (state_q == S_SEND) begin
      case (idx_q)
        3'd0:    m_data = {29'd0, rec_q[162:160]};
        3'd1:    m_data = rec_q[159:128];
        3'd2:    m_data = rec_q[127:96];
        3'd3:    m_data = rec_q[95:64];
        3'd4:    m_data = rec_q[63:32];
        3'd5:    m_data = rec_q[31:0];
        default: m_data = 32'd0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FIFO and status. A pop in the same cycle frees a slot, so a capture into
  // a full FIFO is accepted when the serializer is taking the head record.
  // -------------------------------------------------------------------------
  always_comb begin
    push        = capture_en && !flush && (!full || pop);
    drop        = capture_en && !flush && full && !pop;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    drop_d      = drop_q;
    check_err_d = check_err_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = 7'd0;
      overflow_d  = 1'b0;
      drop_d      = 16'd0;
      check_err_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {6'd0, push} - {6'd0, pop};
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
      if (capture_en && mismatch) check_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 7'd0;
      overflow_q  <= 1'b0;
      drop_q      <= 16'd0;
      check_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
      check_err_q <= check_err_d;
    end
  end

  // Storage array carries no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_rec;
  end

  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign check_err  = check_err_q;

endmodule

// File: tb/tb_zkp_trace_buffer.sv
module tb_zkp_trace_buffer;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc, pc_next, rs1_val, rs2_val, imm;
  logic        is_beq, is_bne;
  logic        capture_en;
  logic        flush;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;
  logic [6:0]  fifo_count;
  logic        overflow;
  logic [15:0] drop_count;
  logic        check_err;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: {m_last, m_data}
  logic [32:0] exp_q[$];
  logic [32:0] exp_w;

  zkp_trace_buffer #(.DEPTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc         (pc),
    .pc_next    (pc_next),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .imm        (imm),
    .is_beq     (is_beq),
    .is_bne     (is_bne),
    .capture_en (capture_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_count (drop_count),
    .check_err  (check_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic model_mismatch(input logic [31:0] p, pn, r1, r2, im,
                                          input logic beq, bne);
    logic        taken;
    logic [31:0] expected;
    taken    = (beq && (r1 == r2)) || (bne && (r1 != r2));
    expected = taken ? (p + im) : (p + 32'd4);
`ifdef TRACE_CHECK_EN
    return (pn != expected);
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_exp(input logic [31:0] p, pn, r1, r2, im, input logic beq, bne);
    logic mm;
    mm = model_mismatch(p, pn, r1, r2, im, beq, bne);
    exp_q.push_back({1'b0, 29'd0, mm, bne, beq});
    exp_q.push_back({1'b0, p});
    exp_q.push_back({1'b0, pn});
    exp_q.push_back({1'b0, r1});
    exp_q.push_back({1'b0, r2});
    exp_q.push_back({1'b1, im});
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic capture(input logic [31:0] p, pn, r1, r2, im, input logic beq, bne);
    pc = p; pc_next = pn; rs1_val = r1; rs2_val = r2; imm = im;
    is_beq = beq; is_bne = bne;
    capture_en = 1'b1;
    @(posedge clk); #1;
    capture_en = 1'b0;
  endtask

  task automatic capture_rand(input logic expect_kept);
    logic [31:0] p, pn, r1, r2, im;
    logic        beq, bne;
    p   = $urandom;
    r1  = $urandom_range(0, 3);
    r2  = $urandom_range(0, 3);
    im  = $urandom;
    beq = 1'($urandom_range(0, 1));
    bne = beq ? 1'b0 : 1'($urandom_range(0, 1));
    pn  = ($urandom_range(0, 1) == 1) ? p + 32'd4 : $urandom;
    if (expect_kept) push_exp(p, pn, r1, r2, im, beq, bne);
    capture(p, pn, r1, r2, im, beq, bne);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain_timeout words_left=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n && !flush && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word got=%h last=%b required=none", m_data, m_last);
      end else begin
        exp_w = exp_q.pop_front();
        if ({m_last, m_data} !== exp_w) begin
          failures++;
          $display("FAIL stream_word got=%b_%h required=%b_%h",
                   m_last, m_data, exp_w[32], exp_w[31:0]);
        end
      end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_valid, m_data, m_last} !== 34'd0) begin
      failures++;
      $display("FAIL reset_stream got=%b_%h_%b required=0", m_valid, m_data, m_last);
    end
    checks++;
    if (fifo_count !== 7'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_fifo count=%0d ovf=%b required=0_0", fifo_count, overflow);
    end
    checks++;
    if (drop_count !== 16'd0 || check_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_status drop=%0d err=%b required=0_0", drop_count, check_err);
    end
    reset_n = 1'b1;
  endtask

  // First capture lands on the first edge after reset release.
  task automatic test_single();
    m_ready = 1'b1;
    push_exp(32'd8, 32'd16, 32'd5, 32'd6, 32'd8, 1'b0, 1'b1);
    capture(32'd8, 32'd16, 32'd5, 32'd6, 32'd8, 1'b0, 1'b1);
    checks++;
    if (fifo_count !== 7'd1 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_after_capture count=%0d valid=%b required=1_0", fifo_count, m_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h2 || fifo_count !== 7'd0) begin
      failures++;
      $display("FAIL single_latency valid=%b data=%h count=%0d required=1_2_0",
               m_valid, m_data, fifo_count);
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_consecutive left=%0d valid=%b required=0_0", exp_q.size(), m_valid);
      exp_q.delete();
    end
    checks++;
    if (check_err !== 1'b0) begin
      failures++;
      $display("FAIL single_check_err got=%b required=0", check_err);
    end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    push_exp(32'd8, 32'd16, 32'd5, 32'd6, 32'd8, 1'b0, 1'b1);
    capture(32'd8, 32'd16, 32'd5, 32'd6, 32'd8, 1'b0, 1'b1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'd16 || m_last !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold cyc=%0d valid=%b data=%h last=%b required=1_10_0",
                 i, m_valid, m_data, m_last);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    m_ready = 1'b1;
    wait_drain(20, "backpressure");
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) capture_rand(i < 9);
    checks++;
    if (fifo_count !== 7'd8 || overflow !== 1'b1 || drop_count !== 16'd1) begin
      failures++;
      $display("FAIL overflow_status count=%0d ovf=%b drop=%0d required=8_1_1",
               fifo_count, overflow, drop_count);
    end
    m_ready = 1'b1;
    wait_drain(120, "overflow");
  endtask

  task automatic test_full_pop_capture();
    do_flush();
    checks++;
    if (overflow !== 1'b0 || drop_count !== 16'd0 || fifo_count !== 7'd0) begin
      failures++;
      $display("FAIL flush_status ovf=%b drop=%0d count=%0d required=0_0_0",
               overflow, drop_count, fifo_count);
    end
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) capture_rand(1'b1);
    m_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (m_last !== 1'b1 || fifo_count !== 7'd8) begin
      failures++;
      $display("FAIL fullpop_at_last last=%b count=%0d required=1_8", m_last, fifo_count);
    end
    capture_rand(1'b1);
    checks++;
    if (fifo_count !== 7'd8 || drop_count !== 16'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL fullpop_no_drop count=%0d drop=%0d ovf=%b required=8_0_0",
               fifo_count, drop_count, overflow);
    end
    checks++;
    if (m_valid !== 1'b1 || {m_last, m_data} !== exp_q[0]) begin
      failures++;
      $display("FAIL fullpop_no_bubble valid=%b data=%h required=1_%h",
               m_valid, m_data, exp_q[0][31:0]);
    end
    // Nine records of six words remain; with no bubbles they finish in 54 edges.
    repeat (54) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL fullpop_stream_gap left=%0d valid=%b required=0_0", exp_q.size(), m_valid);
      exp_q.delete();
    end
  endtask

  task automatic test_checker();
    logic        mm;
    logic [31:0] w0;
    mm = model_mismatch(32'd16, 32'd24, 32'd5, 32'd5, 32'd4, 1'b1, 1'b0);
    w0 = {29'd0, mm, 1'b0, 1'b1};
    m_ready = 1'b0;
    push_exp(32'd16, 32'd24, 32'd5, 32'd5, 32'd4, 1'b1, 1'b0);
    capture(32'd16, 32'd24, 32'd5, 32'd5, 32'd4, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (m_valid !== 1'b1 || m_data !== w0) begin
      failures++;
      $display("FAIL checker_word0 valid=%b data=%h required=1_%h", m_valid, m_data, w0);
    end
    checks++;
    if (check_err !== mm) begin
      failures++;
      $display("FAIL checker_err got=%b required=%b", check_err, mm);
    end
    m_ready = 1'b1;
    wait_drain(20, "checker");
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) capture_rand(1'b0);
    capture_en = 1'b1;
    flush      = 1'b1;
    @(posedge clk); #1;
    capture_en = 1'b0;
    flush      = 1'b0;
    checks++;
    if (fifo_count !== 7'd0 || m_valid !== 1'b0 || check_err !== 1'b0 ||
        overflow !== 1'b0 || drop_count !== 16'd0) begin
      failures++;
      $display("FAIL flush_clear count=%0d valid=%b err=%b ovf=%b drop=%0d required=0_0_0_0_0",
               fifo_count, m_valid, check_err, overflow, drop_count);
    end
    m_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (m_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_idle valid=%b required=0", m_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic saw_valid;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) capture_rand(1'b1);
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b1 || {m_last, m_data} !== exp_q[0]) begin
      failures++;
      $display("FAIL reset_mid_word3 data=%h required=%h", m_data, exp_q[0][31:0]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_data, m_last} !== 34'd0 || fifo_count !== 7'd0 ||
        overflow !== 1'b0 || drop_count !== 16'd0 || check_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs valid=%b data=%h last=%b count=%0d required=0_0_0_0",
               m_valid, m_data, m_last, fifo_count);
    end
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    saw_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (m_valid !== 1'b0) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_resend valid_seen=%b required=0", saw_valid);
    end
    capture_rand(1'b1);
    wait_drain(20, "reset_mid");
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (exp_q.size() <= 18 && $urandom_range(0, 3) == 0) capture_rand(1'b1);
      else begin
        @(posedge clk); #1;
      end
    end
    m_ready = 1'b1;
    wait_drain(200, "random");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0; capture_en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    pc = '0; pc_next = '0; rs1_val = '0; rs2_val = '0; imm = '0;
    is_beq = 1'b0; is_bne = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_pop_capture();
    test_checker();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
